if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Parametrised successor to the IF/ID pipeline register.
- Decouples fetch from decode with a DEPTH-entry instruction queue, a registered ID-side output stage, and a valid/ready handshake on the fetch side.
- The ID side sees the same registered pc/inst pair as before. The zero/NOP bubble is inserted on flush or when the queue is empty.
- Sits between the IF stage and the ID stage in the 5-stage core.

Parameters:
- ADDR_W, 32, width of pc fields.
- INST_W, 32, width of instruction fields.
- DEPTH, 4, queue entries; power of two, >= 2.
- NOP_INST, 0, instruction value driven during a bubble.
- LVL_W, $clog2(DEPTH+1), width of the level output (derived; do not override).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- if_valid, input, 1, fetch presents a valid pc/inst this cycle.
- if_pc, input, ADDR_W, fetched instruction address.
- if_inst, input, INST_W, fetched instruction.
- if_ready, output, 1, queue accepts a fetch this cycle.
- id_stall, input, 1, ID stage is stalled; the output stage must hold.
- ex_b_flag, input, 1, branch/jump resolved in EX; flush.
- id_b_flag, input, 1, branch/jump resolved in ID; flush.
- id_pc, output, ADDR_W, registered pc presented to ID.
- id_inst, output, INST_W, registered instruction presented to ID.
- id_valid, output, 1, id_pc/id_inst hold a real instruction (0 = bubble).
- level, output, LVL_W, current queue occupancy, excluding the output stage.

Behaviour:
- Reset (rst=1 at the clock edge):
  - id_pc=0, id_inst=NOP_INST, id_valid=0.
  - level=0; read/write pointers=0.
  - if_ready=1 from the first cycle after reset.
  - Reset overrides flush, stall and writes.
- if_ready = (level != DEPTH). It is combinational from registered state only, with no path from id_stall or flush inputs.
- Push condition: if_valid && if_ready && !flush, where flush = ex_b_flag || id_b_flag.
- Pop (output-stage load), when !id_stall and not flushing. Priority order:
  1. If level > 0, the output stage loads the queue head; id_valid=1; the read pointer advances.
  2. Else, if a push occurs this cycle, it bypasses the queue straight into the output stage (1-cycle latency, same as the old register); level is unchanged.
  3. Else, the output stage loads a bubble (pc=0, inst=NOP_INST, valid=0).
- When id_stall=1 and no flush: the output stage holds its value. Pushes still fill the queue.
- Simultaneous push and pop with level > 0: entry written at the write pointer, head read. level is unchanged and FIFO order is preserved.
- Flush, priority below reset and above everything else:
  - Output stage becomes a bubble; level=0; both pointers=0.
  - The incoming fetch that cycle is discarded.
  - Flush takes effect even while id_stall=1.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. level is tracked separately, so full and empty are unambiguous.
- A push is never accepted when level==DEPTH. A push with if_ready=0 is ignored and fetch must hold its data.
- A pop from an empty queue never occurs; the bypass or bubble path is used instead.
- id_valid is informational. Downstream treats NOP_INST at pc 0 as a bubble, as before.

Test Plan:
- Reset, then a single fetch (pc=0x100, inst=0x00500093), no stall -> next cycle id_pc=0x100, id_inst=0x00500093, id_valid=1, level=0 (bypass); the following cycle is a bubble.
- id_stall=1; push 4 fetches (pc 0x200..0x20C) -> level reaches 4, if_ready=0, a 5th push (pc=0x210) is rejected and the output holds. Release id_stall -> ID sees 0x200, 0x204, 0x208, 0x20C in order, then 0x210 once re-presented.
- Continuous fetch with level=2 and no stall -> level stays 2 each cycle, output order is strictly sequential, pointer wrap past DEPTH-1 shows no gap or duplicate.
- level=3 with id_stall=1; assert ex_b_flag together with if_valid (pc=0x300) -> next cycle id_valid=0, id_inst=NOP_INST, id_pc=0, level=0; 0x300 is never delivered. Repeat using id_b_flag.
- Assert rst mid-stream (level=2, output valid, id_stall=1, if_valid=1) -> next cycle all outputs at reset values, level=0, if_ready=1.

Source files
------------

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The master side is the surrounding pipeline and the slave side is the queue.
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH + 1)
);
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              id_stall;
    logic              ex_b_flag;
    logic              id_b_flag;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_valid;
    logic [LVL_W-1:0]  level;

    modport master (
        output if_valid, if_pc, if_inst, id_stall, ex_b_flag, id_b_flag,
        input  if_ready, id_pc, id_inst, id_valid, level
    );

    modport slave (
        input  if_valid, if_pc, if_inst, id_stall, ex_b_flag, id_b_flag,
        output if_ready, id_pc, id_inst, id_valid, level
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry FIFO feeding a registered ID output stage,
// with an empty-queue bypass so a lone fetch still reaches ID one cycle later.
module if_id_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter int                LVL_W    = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          rst,
    if_id_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [LVL_W-1:0]  level_q;

    logic [ADDR_W-1:0] id_pc_q;
    logic [INST_W-1:0] id_inst_q;
    logic              id_valid_q;

    logic flush;
    logic ready;
    logic push;
    logic advance;
    logic pop;
    logic bypass;
    logic wr_en;

    always_comb begin
        flush   = bus.ex_b_flag || bus.id_b_flag;
        ready   = (level_q != FULL_LVL);
        push    = bus.if_valid && ready && !flush;
        advance = !bus.id_stall && !flush;
        pop     = advance && (level_q != '0);
        // An empty queue hands the fetch straight to the output stage instead of storing it.
        bypass  = advance && (level_q == '0) && push;
        wr_en   = push && !bypass;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr]   <= bus.if_pc;
            inst_mem[wr_ptr] <= bus.if_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !wr_en) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
        end else if (advance) begin
            if (pop) begin
                id_pc_q    <= pc_mem[rd_ptr];
                id_inst_q  <= inst_mem[rd_ptr];
                id_valid_q <= 1'b1;
            end else if (bypass) begin
                id_pc_q    <= bus.if_pc;
                id_inst_q  <= bus.if_inst;
                id_valid_q <= 1'b1;
            end else begin
                id_pc_q    <= '0;
                id_inst_q  <= NOP_INST;
                id_valid_q <= 1'b0;
            end
        end
    end

    assign bus.if_ready = ready;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
    assign bus.id_valid = id_valid_q;
    assign bus.level    = level_q;
endmodule
